// File: rtl/mem_responder.sv
// Arbitrates icache and dcache requests onto a single RAM port: data first,
// with retry on RAM error, timeout with a fixed error word, and abort on request drop.
module mem_responder #(
    parameter int unsigned TIMEOUT = 255,
    parameter logic [31:0] ERRVAL  = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    typedef enum logic [2:0] {IDLE, DACC, IACC, RETRY, DRESP, IRESP} state_e;
    typedef enum logic [1:0] {RS_FREE, RS_BUSY, RS_ACCESS, RS_ERROR} ramstate_e;

    state_e      state_q, state_d;
    logic        side_d_q, side_d_d;
    logic        rw_q, rw_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] store_q, store_d;
    logic [31:0] iload_q, iload_d;
    logic [31:0] dload_q, dload_d;
    logic        ren_q, ren_d;
    logic        wen_q, wen_d;
    logic        iwait_q, iwait_d;
    logic        dwait_q, dwait_d;

    logic        d_req;
    logic        req_held;
    logic        timeout_hit;
    logic [7:0]  cnt_inc;

    assign d_req       = dREN | dWEN;
    assign req_held    = side_d_q ? d_req : iREN;
    assign cnt_inc     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    // Timeout is judged on the count this cycle will reach, so TIMEOUT cycles are spent waiting.
    assign timeout_hit = (32'(cnt_q) + 32'd1) >= 32'(TIMEOUT);

    always_comb begin
        state_d  = state_q;
        side_d_d = side_d_q;
        rw_d     = rw_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        store_d  = store_q;
        iload_d  = iload_q;
        dload_d  = dload_q;

        case (state_q)
            IDLE: begin
                if (d_req) begin
                    state_d  = DACC;
                    side_d_d = 1'b1;
                    rw_d     = dWEN;
                    addr_d   = daddr;
                    store_d  = dstore;
                    cnt_d    = '0;
                end else if (iREN) begin
                    state_d  = IACC;
                    side_d_d = 1'b0;
                    addr_d   = iaddr;
                    cnt_d    = '0;
                end
            end
            DACC, IACC, RETRY: begin
                if (!req_held) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (state_q != RETRY && ramstate == RS_ACCESS) begin
                        state_d = side_d_q ? DRESP : IRESP;
                        if (side_d_q) dload_d = ramload;
                        else          iload_d = ramload;
                    end else if (timeout_hit) begin
                        state_d = side_d_q ? DRESP : IRESP;
                        if (!side_d_q)  iload_d = ERRVAL;
                        else if (!rw_q) dload_d = ERRVAL;
                    end else if (state_q == RETRY) begin
                        state_d = side_d_q ? DACC : IACC;
                    end else if (ramstate == RS_ERROR) begin
                        state_d = RETRY;
                    end
                end
            end
            DRESP, IRESP: state_d = IDLE;
            default:      state_d = IDLE;
        endcase

        ren_d   = (state_d == IACC) || (state_d == DACC && !rw_d);
        wen_d   = (state_d == DACC) && rw_d;
        iwait_d = (state_d != IRESP);
        dwait_d = (state_d != DRESP);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            side_d_q <= 1'b0;
            rw_q     <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= '0;
            store_q  <= '0;
            iload_q  <= '0;
            dload_q  <= '0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            iwait_q  <= 1'b1;
            dwait_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            side_d_q <= side_d_d;
            rw_q     <= rw_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            iload_q  <= iload_d;
            dload_q  <= dload_d;
            ren_q    <= ren_d;
            wen_q    <= wen_d;
            iwait_q  <= iwait_d;
            dwait_q  <= dwait_d;
        end
    end

    assign iwait    = iwait_q;
    assign dwait    = dwait_q;
    assign iload    = iload_q;
    assign dload    = dload_q;
    assign ramREN   = ren_q;
    assign ramWEN   = wen_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles an access waits for RAM ACCESS before forced completion.
REQ-002 Parameter ERRVAL, default 32'hBAD1BAD1: data returned on timeout.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST  in  1  asynchronous, active-high reset.
REQ-005 iREN  in  1  instruction read request from icache, held until completion.
REQ-006 iaddr  in  32  instruction word address.
REQ-007 iwait  out  1  0 = iload valid this cycle (completion), else 1.
REQ-008 iload  out  32  instruction read data.
REQ-009 dREN  in  1  data read request, held until completion.
REQ-010 dWEN  in  1  data write request, held until completion.
REQ-011 daddr  in  32  data address.
REQ-012 dstore  in  32  data write value.
REQ-013 dwait  out  1  0 = data access complete this cycle, else 1.
REQ-014 dload  out  32  data read result.
REQ-015 ramREN  out  1  RAM read enable.
REQ-016 ramWEN  out  1  RAM write enable.
REQ-017 ramaddr  out  32  RAM address.
REQ-018 ramstore  out  32  RAM write data.
REQ-019 ramload  in  32  RAM read data.
REQ-020 ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Function
REQ-021 States: IDLE, DACC, IACC, RETRY, DRESP, IRESP; all outputs registered or decoded from state plus latched registers only.
REQ-022 IDLE: dREN|dWEN -> DACC, latching daddr, dstore, rw=dWEN; else iREN -> IACC, latching iaddr; else stay.
REQ-023 Data has priority: dREN|dWEN and iREN together -> DACC; the instruction request is served after the data completion.
REQ-024 dREN and dWEN together -> treated as write.
REQ-025 DACC: ramaddr=latched daddr, ramWEN=rw, ramREN=!rw, ramstore=latched dstore; IACC: ramaddr=latched iaddr, ramREN=1, ramWEN=0.
REQ-026 Outside DACC/IACC: ramREN=ramWEN=0; ramaddr and ramstore hold last values.
REQ-027 DACC/IACC with ramstate==ACCESS: capture ramload into dload/iload; next state DRESP/IRESP.
REQ-028 DRESP/IRESP last exactly one cycle with dwait=0/iwait=0; then IDLE.
REQ-029 Minimum latency: request sampled in cycle 0, RAM enable in cycle 1, ACCESS in cycle 1 -> wait low in cycle 2.
REQ-030 DACC/IACC with ramstate==ERROR: go to RETRY (enables low one cycle), then return to the same access state; the cycle counter is not cleared.
REQ-031 8-bit cycle counter: cleared on entry from IDLE, +1 each cycle in DACC/IACC/RETRY, saturating at 255.
REQ-032 Counter reaching TIMEOUT without ACCESS -> load ERRVAL into dload/iload (write: dload unchanged) and enter DRESP/IRESP.
REQ-033 Requester drops its enable in DACC/IACC/RETRY -> abort to IDLE next cycle; no wait-low pulse; load registers unchanged.
REQ-034 iwait=0 only in IRESP; dwait=0 only in DRESP; never both low in one cycle.
REQ-035 IRESP/DRESP ignore new requests; these are sampled again in IDLE, one cycle of gap minimum.

Reset
REQ-036 On RST: state=IDLE, counter=0, iwait=dwait=1, iload=dload=0, ramREN=ramWEN=0, ramaddr=ramstore=0.
REQ-037 RST mid-access takes effect immediately (asynchronous), with no completion pulse; operation resumes from IDLE after release.

Verification
REQ-038 iREN=1, iaddr=0x40, ramstate=ACCESS and ramload=0x8C010004 from cycle 1 -> ramREN=1/ramaddr=0x40 in cycle 1; iwait=0 and iload=0x8C010004 in cycle 2 only.
REQ-039 iREN and dWEN both asserted, daddr=0x100, dstore=0xDEAD -> write served first (ramWEN=1, ramaddr=0x100, ramstore=0xDEAD); dwait pulses; then the IACC access; iwait pulses later.
REQ-040 dREN held, ramstate=BUSY 3 cycles then ACCESS with ramload=0x1234 -> dwait=0 one cycle later, dload=0x1234.
REQ-041 ramstate=ERROR once during IACC -> one RETRY cycle with ramREN=0, then reissue; completes normally on ACCESS.
REQ-042 TIMEOUT=4, dREN held, ramstate=BUSY forever -> dwait=0 after counter reaches 4, dload=0xBAD1BAD1.
REQ-043 RST asserted in IACC, or iREN dropped in IACC -> no iwait pulse, ramREN=0 next cycle, state IDLE.
